reaction_display: RTL and testbench
===================================

# reaction_display

Downstream display stage for the reaction timer. Captures the 12-bit millisecond result and the slow flag when the timer presents a result, converts the binary value to four BCD digits with a sequential shift-add-3 converter, and drives a 4-digit multiplexed active-low seven-segment display with leading-zero blanking and a slow indicator.

## Interface
- SCAN_DIV, 50000: clock cycles each digit is enabled; sim uses 4. Legal values are ≥ 2.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- load  in  1  single-cycle strobe: rtime/slow valid.
- rtime  in  12  reaction time in ms, binary, 0..4095.
- slow  in  1  result saturated / too slow.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  digit anodes, active-low; an[0] = ones digit.
- busy  out  1  conversion in progress.

## Operation
- FSM states: IDLE, CONVERT, SHOW.
  - IDLE: display blank.
  - load in IDLE or SHOW: latch rtime into a 12-bit shift register; latch slow; clear the 16-bit BCD accumulator; go to CONVERT.
- CONVERT runs 12 iterations, one per cycle:
  - each BCD nibble ≥ 5 gets +3;
  - then {bcd, shift} shifts left by 1.
- After iteration 12, the 4 BCD digits and the latched slow flag are written atomically to the display registers; go to SHOW.
- load while in CONVERT is ignored; no queueing.
- Display registers change only on conversion completion or rst; the scan never shows a partial result.
- Leading-zero blanking: digits above the most-significant nonzero digit are blanked, with their an bit held high. Digit 0 is always shown, so value 0 displays "0".
- dp is low only while digit 0 is scanned and the shown slow flag = 1; otherwise high.
- Scan:
  - prescale counter counts 0..SCAN_DIV-1;
  - on wrap, digit index increments 0→1→2→3→0;
  - runs continuously in all states.
  - Exactly one an bit is low when the scanned digit is not blanked; in IDLE, all an = 1111.
- Any rtime value 0..4095 is shown exactly; there is no saturation in this block (upstream clamps to 2000).

## Timing
- Reset values: an=4'b1111, seg=7'b1111111, dp=1, busy=0, state IDLE, digit index 0, prescale 0, display registers 0.
- rst mid-CONVERT aborts the conversion and returns to IDLE with the blank display; rst has priority over load.
- load sampled high at edge N:
  - busy=1 for cycles N+1..N+12;
  - busy=0 and new digits visible from N+13;
  - conversion latency is 13 cycles from the load edge.
- seg/an/dp are registered and update on the same edge as the digit index.
- The first digit shown after a conversion is whichever digit the scan is currently on; the scan phase is not reset by load.
- load at N+13 (first cycle of SHOW) is accepted.

## Structure
- Package reaction_pkg:
  - SEG_BLANK = 7'b1111111;
  - the function/array SEG_DIGIT[0..9] (e.g. '0' = 7'b1000000, '1' = 7'b1111001);
  - the FSM state enum;
  - RT_WIDTH = 12 and BCD_DIGITS = 4.
- Sub-module bin2bcd_seq:
  - ports: start, bin[11:0], busy, done (1-cycle), bcd[15:0];
  - contains the shift-add-3 iteration counter.
- The top level holds the FSM glue, display registers, blanking logic and scan.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset: assert rst 2 cycles → an=1111, seg=1111111, dp=1, busy=0 on every cycle for 32 cycles after release.
- load rtime=347, slow=0 at edge N → busy high exactly N+1..N+12. Then over 16 cycles, an[0]/an[1]/an[2] show 7/4/3 patterns (7'b1111000, 7'b0011001, 7'b0110000), an[3] never low, dp=1.
- load rtime=2000, slow=1 → digits 2,0,0,0 all shown (no blanking of interior zeros); dp=0 only while an=1110.
- load rtime=0 → only an[0] ever low, seg=7'b1000000. Then load rtime=4095 → digits 4,0,9,5.
- Load during CONVERT: load 347, then load 1234 at N+5 → result 347, busy drops at N+13. A load of 1234 at N+13 is accepted and shows 1234 from N+26.
- Reset at N+6 during conversion → IDLE next cycle, blank display, busy=0. A subsequent load completes normally.

Source files
------------

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared widths, FSM states and seven-segment encodings for the reaction display
package reaction_pkg;
  localparam int RT_WIDTH = 12;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_WIDTH = 4 * BCD_DIGITS;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle
module bin2bcd_seq
  import reaction_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RT_WIDTH-1:0]  bin,
  output logic                 busy,
  output logic                 done,
  output logic [BCD_WIDTH-1:0] bcd
);
  localparam int CW = $clog2(RT_WIDTH + 1);
  logic [RT_WIDTH-1:0] sr;
  logic [BCD_WIDTH-1:0] acc, adj;
  logic [CW-1:0] cnt;
  always_comb begin
    adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  // bcd is the accumulator after the current iteration, so done and bcd are valid together
  assign bcd = {adj[BCD_WIDTH-2:0], sr[RT_WIDTH-1]};
  assign busy = cnt != '0;
  assign done = cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      sr <= '0;
    end else if (start) begin
      cnt <= CW'(RT_WIDTH);
      acc <= '0;
      sr <= bin;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      acc <= bcd;
      sr <= sr << 1;
    end
  end
endmodule

// File: rtl/reaction_display.sv
// reaction_display: latches a reaction result, converts it to BCD and scans it onto a 4-digit display
module reaction_display
  import reaction_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [RT_WIDTH-1:0] rtime,
  input  logic                slow,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [3:0]          an,
  output logic                busy
);
  localparam int PW = $clog2(SCAN_DIV);
  state_t state, state_n;
  logic start, done, slow_l, disp_slow, wrap, on, idle;
  logic [BCD_WIDTH-1:0] cvt_bcd, disp_bcd;
  logic [PW-1:0] pre;
  logic [1:0] dig, nd;
  logic [3:0] nib;
  assign start = load && state != CONVERT;
  always_comb begin
    state_n = state;
    if (state == CONVERT) state_n = done ? SHOW : CONVERT;
    else if (load) state_n = CONVERT;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  bin2bcd_seq u_cvt (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bin(rtime),
    .busy(busy),
    .done(done),
    .bcd(cvt_bcd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      slow_l <= 1'b0;
      disp_bcd <= '0;
      disp_slow <= 1'b0;
    end else begin
      if (start) slow_l <= slow;
      if (done) begin
        disp_bcd <= cvt_bcd;
        disp_slow <= slow_l;
      end
    end
  end
  // outputs are computed for the digit the scan is about to move to
  assign wrap = pre == PW'(SCAN_DIV - 1);
  assign nd = dig + 2'd1;
  assign nib = disp_bcd[{nd, 2'b00} +: 4];
  assign idle = state == IDLE;
  assign on = !idle && (nd == 2'd0 || |(disp_bcd >> {nd, 2'b00}));
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      dig <= 2'd0;
      an <= 4'b1111;
      seg <= SEG_BLANK;
      dp <= 1'b1;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap) begin
        dig <= nd;
        an <= on ? ~(4'b0001 << nd) : 4'b1111;
        seg <= on && nib <= 4'd9 ? SEG_DIGIT[nib] : SEG_BLANK;
        dp <= !(on && nd == 2'd0 && disp_slow);
      end
    end
  end
endmodule

// File: tb/tb_reaction_display.sv
// tb_reaction_display: directed checks of conversion timing, blanking, dp and scan output
module tb_reaction_display;
  logic clk = 0, rst = 1, load = 0, slow = 0;
  logic [11:0] rtime = 0;
  logic [6:0] seg;
  logic dp, busy;
  logic [3:0] an;
  int total = 0, bad = 0;
  localparam logic [6:0] SEGS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [12:0] BLANK = {4'hf, 7'h7f, 1'b1, 1'b0};

  reaction_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .rtime(rtime), .slow(slow),
    .seg(seg), .dp(dp), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start(input int rt, input bit sl);
    @(negedge clk);
    load = 1;
    rtime = 12'(rt);
    slow = sl;
    @(posedge clk);
    #1 load = 0;
  endtask

  task automatic busy_win();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      chk($sformatf("busy%0d", k + 1), busy, k < 12);
    end
  endtask

  task automatic conv_inj(input int inj_k, input int inj_rt);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == inj_k + 1) load = 0;
      chk($sformatf("busy_inj%0d", k + 1), busy, k < 12);
      if (k == inj_k) begin
        load = 1;
        rtime = 12'(inj_rt);
      end
    end
  endtask

  task automatic obs(input int v, input bit sl);
    int d[4];
    bit [3:0] shown, seen;
    int p, idx;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d[i] = (v / p) % 10;
      shown[i] = (i == 0) || (v >= p);
      p *= 10;
    end
    repeat (4) @(negedge clk);
    seen = 0;
    repeat (16) begin
      @(negedge clk);
      if (an == 4'hf) chk($sformatf("blank_%0d", v), {shown != 4'hf, seg, dp}, {1'b1, 8'hff});
      else begin
        idx = 0;
        for (int j = 3; j >= 0; j--) if (!an[j]) idx = j;
        chk($sformatf("onehot_%0d", v), $onehot(~an), 1);
        chk($sformatf("dig%0d_%0d", idx, v), {seg, dp}, {SEGS[d[idx]], !(idx == 0 && sl)});
        seen[idx] = 1;
      end
    end
    chk($sformatf("seen_%0d", v), seen, shown);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("reset", {an, seg, dp, busy}, BLANK);
    end
    start(347, 0); busy_win(); obs(347, 0);
    start(2000, 1); busy_win(); obs(2000, 1);
    start(0, 0); busy_win(); obs(0, 0);
    start(4095, 0); busy_win(); obs(4095, 0);
    start(347, 0); conv_inj(4, 1234); obs(347, 0);
    start(347, 0); conv_inj(12, 1234);
    @(posedge clk);
    #1 load = 0;
    busy_win(); obs(1234, 0);
    start(347, 0);
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid", {an, seg, dp, busy}, BLANK);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("idle_after_rst", {an, seg, dp, busy}, BLANK);
    end
    start(55, 1); busy_win(); obs(55, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
